// File: rtl/crc_stream.sv
// crc_stream: streaming MSB-first CRC-32 engine that passes payload through and appends the FCS.
// Build with CRC_STREAM_CHECK_EN defined to enable check mode (mode input and RESIDUE compare).
`timescale 1ns/1ps
module crc_stream #(
    parameter int unsigned DW      = 8,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE = 32'hC704DD7B
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] d,
    input  logic          d_valid,
    input  logic          sof,
    input  logic          eof,
    input  logic          mode,
    output logic [DW-1:0] q,
    output logic          q_valid,
    output logic          busy,
    output logic [31:0]   crc_out,
    output logic          done,
    output logic          crc_ok,
    output logic          ovf
);

    localparam int unsigned NBEATS = 32 / DW;
    localparam int unsigned CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_APPEND} state_t;

    state_t        r_state, w_state_nx;
    logic [31:0]   r_crc, w_crc_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          r_mode, w_mode_nx;
    logic [DW-1:0] r_q, w_q_nx;
    logic          r_qv, w_qv_nx;
    logic          r_done, w_done_nx;
    logic          r_ok, w_ok_nx;
    logic          r_ovf, w_ovf_nx;

    logic [31:0]   w_base, w_crc_beat, w_fcs, w_fcs_sh;
    int unsigned   w_shamt;
    logic          w_accept, w_mode_in, w_mode_eff, w_ok_cmp;

    function automatic logic [31:0] crc_beat(input logic [31:0] c, input logic [DW-1:0] b);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < DW; i++) begin
            if (r[31] ^ b[DW-1-i])
                r = {r[30:0], 1'b0} ^ POLY;
            else
                r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

`ifdef CRC_STREAM_CHECK_EN
    assign w_mode_in = mode;
    assign w_ok_cmp  = (w_crc_beat == RESIDUE);
`else
    logic w_cfg_unused;
    assign w_mode_in    = 1'b0;
    assign w_ok_cmp     = 1'b0;
    assign w_cfg_unused = mode ^ (^RESIDUE);
`endif

    // A sof beat always restarts from INIT, whether it arrives in IDLE or mid-frame.
    assign w_base     = sof ? INIT : r_crc;
    assign w_crc_beat = crc_beat(w_base, d);
    assign w_mode_eff = sof ? w_mode_in : r_mode;
    assign w_accept   = d_valid & (sof | (r_state == S_CALC));
    assign w_fcs      = r_crc ^ XOROUT;
    assign w_shamt    = DW * 32'(r_cnt);
    assign w_fcs_sh   = w_fcs << w_shamt;

    always_comb begin
        w_state_nx = r_state;
        w_crc_nx   = r_crc;
        w_mode_nx  = r_mode;
        w_cnt_nx   = r_cnt;
        w_q_nx     = r_q;
        w_qv_nx    = 1'b0;
        w_done_nx  = 1'b0;
        w_ok_nx    = r_ok;
        w_ovf_nx   = 1'b0;
        case (r_state)
            S_IDLE, S_CALC: begin
                if (w_accept) begin
                    w_crc_nx   = w_crc_beat;
                    w_q_nx     = d;
                    w_qv_nx    = 1'b1;
                    w_state_nx = S_CALC;
                    if (sof)
                        w_mode_nx = w_mode_in;
                    if (eof) begin
                        if (w_mode_eff) begin
                            w_state_nx = S_IDLE;
                            w_done_nx  = 1'b1;
                            w_ok_nx    = w_ok_cmp;
                        end else begin
                            w_state_nx = S_APPEND;
                            w_cnt_nx   = '0;
                        end
                    end
                end
            end
            S_APPEND: begin
                w_q_nx   = w_fcs_sh[31 -: DW];
                w_qv_nx  = 1'b1;
                w_ovf_nx = d_valid;
                if (r_cnt == LAST) begin
                    w_done_nx  = 1'b1;
                    w_ok_nx    = 1'b0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_crc   <= INIT;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_q     <= '0;
            r_qv    <= 1'b0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_crc   <= w_crc_nx;
            r_cnt   <= w_cnt_nx;
            r_mode  <= w_mode_nx;
            r_q     <= w_q_nx;
            r_qv    <= w_qv_nx;
            r_done  <= w_done_nx;
            r_ok    <= w_ok_nx;
            r_ovf   <= w_ovf_nx;
        end
    end

    assign q       = r_q;
    assign q_valid = r_qv;
    assign busy    = (r_state == S_APPEND);
    assign crc_out = r_crc;
    assign done    = r_done;
    assign crc_ok  = r_ok;
    assign ovf     = r_ovf;

endmodule
